// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ
// requesters, one transaction in flight, with a done watchdog and late-done drain.
module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        m_start_write,
  output logic                        m_start_read,
  output logic [ADDR_W-1:0]           m_write_address,
  output logic [ADDR_W-1:0]           m_read_address,
  output logic [DATA_W-1:0]           m_write_data,
  input  logic [DATA_W-1:0]           m_read_data,
  input  logic                        m_write_done,
  input  logic                        m_read_done,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [GID_W-1:0]   last_q, last_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic               wr_q, wr_d;
  logic               drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               start_wr_q, start_wr_d;
  logic               start_rd_q, start_rd_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d;

  logic               gnt_found;
  logic [GID_W-1:0]   gnt_idx;
  logic               done_match;

  // First requester at or after last+1, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = GID_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign done_match = wr_q ? m_write_done : m_read_done;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    wr_d        = wr_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    start_wr_d  = 1'b0;
    start_rd_d  = 1'b0;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    wdata_d     = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          last_d               = gnt_idx;
          grant_d              = gnt_idx;
          wr_d                 = req_write[gnt_idx];
          waddr_d              = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          raddr_d              = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          wdata_d              = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          req_ready_d[gnt_idx] = 1'b1;
          start_wr_d           = req_write[gnt_idx];
          start_rd_d           = !req_write[gnt_idx];
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        drain_d = 1'b0;
        if (done_match) begin
          rsp_rdata_d          = wr_q ? '0 : m_read_data;
          rsp_err_d            = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_match) begin
          rsp_rdata_d          = wr_q ? '0 : m_read_data;
          rsp_err_d            = 1'b0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = S_RESP;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (cnt_q == CNT_MAX) begin
            rsp_rdata_d          = '0;
            rsp_err_d            = 1'b1;
            drain_d              = 1'b1;
            rsp_valid_d[grant_q] = 1'b1;
            state_d              = S_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = drain_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        // Swallow the late done so it cannot complete the next command.
        if (done_match) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      last_q      <= GID_W'(NUM_REQ - 1);
      grant_q     <= '0;
      wr_q        <= 1'b0;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      start_wr_q  <= 1'b0;
      start_rd_q  <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      start_wr_q  <= start_wr_d;
      start_rd_q  <= start_rd_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign m_start_write   = start_wr_q;
  assign m_start_read    = start_rd_q;
  assign m_write_address = waddr_q;
  assign m_read_address  = raddr_q;
  assign m_write_data    = wdata_q;
  assign busy            = busy_q;
  assign grant_id        = grant_q;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Scoreboard bench: expected transactions are queued at stimulus time; a negedge
// monitor checks each grant and pops/checks each response.
module tb_axi_lite_cmd_arbiter;
  localparam int NR = 2, AW = 32, DW = 32, TMO = 8;

  logic             clk = 1'b0, arst = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err, m_start_write, m_start_read, busy;
  logic [AW-1:0]    m_write_address, m_read_address;
  logic [DW-1:0]    m_write_data;
  logic [DW-1:0]    m_read_data = '0;
  logic             m_write_done = 1'b0, m_read_done = 1'b0;
  logic [$clog2(NR)-1:0] grant_id;

  axi_lite_cmd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_start_write(m_start_write), .m_start_read(m_start_read),
    .m_write_address(m_write_address), .m_read_address(m_read_address),
    .m_write_data(m_write_data), .m_read_data(m_read_data),
    .m_write_done(m_write_done), .m_read_done(m_read_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          id;
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit          err;
    int          lat;
    bit          tmo;
    bit          wrong;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0;
  int   n_grants = 0, start_cyc = 0, tb_last = NR - 1;
  bit   start_viol = 1'b0, late_go = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Master model: done arrives lat negedges after the start is seen.
  int mst_cnt = -1;
  bit mst_wr, mst_tmo, mst_wrong;
  logic [DW-1:0] mst_rd;
  always @(negedge clk) begin
    m_write_done = 1'b0;
    m_read_done  = 1'b0;
    if (arst) mst_cnt = -1;
    else begin
      if ((m_start_write || m_start_read) && sbq.size() > 0) begin
        mst_wr    = m_start_write;
        mst_tmo   = sbq[0].tmo;
        mst_wrong = sbq[0].wrong;
        mst_rd    = sbq[0].rdata;
        mst_cnt   = sbq[0].tmo ? 0 : sbq[0].lat;
      end
      if (mst_cnt == 0 && (!mst_tmo || late_go)) begin
        if (mst_wr) m_write_done = 1'b1;
        else begin m_read_done = 1'b1; m_read_data = mst_rd; end
        mst_cnt = -1;
      end else if (mst_cnt > 0) begin
        if (mst_cnt == 1 && mst_wrong) begin
          if (mst_wr) m_read_done = 1'b1; else m_write_done = 1'b1;
        end
        mst_cnt--;
      end
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!arst) begin
      if ((m_start_write || m_start_read) && req_ready == '0) start_viol = 1'b1;
      if (req_ready != '0) begin
        n_grants++;
        start_cyc = cyc;
        if (sbq.size() == 0) chk("grant_unexpected", 1, 0);
        else begin
          chk("ready_onehot", req_ready, 64'(1) << sbq[0].id);
          chk("grant_id", grant_id, sbq[0].id);
          chk("start_kind", {m_start_write, m_start_read}, {sbq[0].wr, !sbq[0].wr});
          chk("waddr", m_write_address, sbq[0].addr);
          chk("raddr", m_read_address, sbq[0].addr);
          chk("wdata", m_write_data, sbq[0].wdata);
          chk("busy_issue", busy, 1);
        end
      end
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          chk("rsp_onehot", rsp_valid, 64'(1) << mon_e.id);
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", rsp_err, mon_e.err);
          chk("rsp_lat", cyc - start_cyc, mon_e.lat + 1);
          chk("rsp_gid", grant_id, mon_e.id);
        end
      end
    end
  end

  task automatic queue_txn(input int id, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd,
                           input int lat, input bit tmo, input bit wrong);
    exp_t e;
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
    e.id = id; e.wr = wr; e.addr = a; e.wdata = d;
    e.rdata = (wr || tmo) ? '0 : rd;
    e.err = tmo; e.lat = tmo ? TMO : lat; e.tmo = tmo; e.wrong = wrong;
    sbq.push_back(e);
  endtask

  task automatic wait_grants(input int target, input int budget, input string tag);
    int n = 0;
    while (n_grants < target && n < budget) begin @(posedge clk); #1; n++; end
    chk(tag, n_grants, target);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < budget) begin @(posedge clk); #1; n++; end
    chk(tag, {sbq.size() == 0, busy}, 2'b10);
  endtask

  task automatic run_one(input int id, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rd,
                         input int lat, input bit wrong);
    int g0;
    g0 = n_grants;
    queue_txn(id, wr, a, d, rd, lat, 1'b0, wrong);
    req_valid[id] = 1'b1;
    wait_grants(g0 + 1, 20, "grant_wait");
    req_valid[id] = 1'b0;
    tb_last = id;
    wait_idle(60, "rsp_wait");
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_rdata, rsp_err, m_start_write,
                        m_start_read, busy, grant_id}, 0);
    chk({tag, "_waddr"}, m_write_address, 0);
    chk({tag, "_raddr"}, m_read_address, 0);
    chk({tag, "_wdata"}, m_write_data, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    int g0, dc, g;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    arst = 1'b0;
    @(posedge clk); #1;

    // Single write with command-latency check.
    g0 = n_grants;
    queue_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 3, 1'b0, 1'b0);
    dc = cyc;
    req_valid[0] = 1'b1;
    wait_grants(g0 + 1, 20, "grant_wait");
    req_valid[0] = 1'b0;
    chk("cmd_lat", start_cyc, dc + 1);
    tb_last = 0;
    wait_idle(60, "rsp_wait");

    run_one(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    run_one(0, 1'b0, 32'h20, 32'h0, 32'h12345678, 0, 1'b0);   // done during ISSUE
    run_one(0, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 4, 1'b1);   // stray write_done
    run_one(1, 1'b1, 32'h34, 32'hA5A5A5A5, 32'h0, 3, 1'b1);   // stray read_done

    // Fairness: both held for six transactions.
    g0 = n_grants;
    for (int i = 0; i < 6; i++) begin
      g = (tb_last + 1) % NR;
      tb_last = g;
      if (g == 0) queue_txn(0, 1'b1, 32'h100, 32'h11110000, 32'h0, 1 + i % 3, 1'b0, 1'b0);
      else        queue_txn(1, 1'b0, 32'h200, 32'h22220000, 32'hF0000000 + i, 1 + i % 3, 1'b0, 1'b0);
    end
    req_valid = 2'b11;
    wait_grants(g0 + 6, 200, "fair_grants");
    req_valid = 2'b00;
    wait_idle(60, "fair_idle");

    // Timeout, then a new request blocked in DRAIN until the late done.
    g0 = n_grants;
    queue_txn(0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    req_valid[0] = 1'b1;
    wait_grants(g0 + 1, 20, "tmo_grant");
    req_valid[0] = 1'b0;
    tb_last = 0;
    for (int n = 0; n < 40 && sbq.size() != 0; n++) begin @(posedge clk); #1; end
    chk("tmo_rsp_seen", sbq.size(), 0);
    queue_txn(1, 1'b1, 32'h44, 32'h55AA55AA, 32'h0, 1, 1'b0, 1'b0);
    req_valid[1] = 1'b1;
    g0 = n_grants;
    repeat (6) begin @(posedge clk); #1; end
    chk("drain_blocks", n_grants, g0);
    chk("drain_busy", busy, 1);
    late_go = 1'b1;
    @(posedge clk); #1;
    late_go = 1'b0;
    wait_grants(g0 + 1, 20, "post_drain_grant");
    req_valid[1] = 1'b0;
    tb_last = 1;
    wait_idle(60, "post_drain_idle");

    // Asynchronous reset in the middle of WAIT.
    g0 = n_grants;
    queue_txn(0, 1'b0, 32'h80, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    req_valid[0] = 1'b1;
    wait_grants(g0 + 1, 20, "rst_txn_grant");
    req_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy, 1);
    #2;
    arst = 1'b1;
    #1;
    chk_reset("midreset");
    sbq.delete();
    @(posedge clk); #1;
    arst = 1'b0;
    tb_last = NR - 1;
    g0 = n_grants;
    for (int i = 0; i < 2; i++) begin
      g = (tb_last + 1) % NR;
      tb_last = g;
      queue_txn(g, 1'b0, 32'h300 + 32'(g), 32'h0, 32'hB0B00000 + 32'(g), 1, 1'b0, 1'b0);
    end
    req_valid = 2'b11;
    wait_grants(g0 + 2, 40, "rst_fair_grants");
    req_valid = 2'b00;
    wait_idle(60, "rst_fair_idle");

    chk("start_only_in_issue", start_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
